// File: rtl/capture_ctrl.sv
// Circular pre/post-trigger capture sequencer for a ram_dc block (both RAM clocks on clk).
// Streams samples into RAM while armed, freezes post_count samples after the trigger, then replays oldest-first.
module capture_ctrl #(
  parameter int unsigned DATAWIDTH = 18,
  parameter int unsigned ADDRWIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 trig,
  input  logic [ADDRWIDTH-1:0] post_count,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic [ADDRWIDTH-1:0] ram_wr_addr,
  output logic [DATAWIDTH-1:0] ram_wr_data,
  output logic                 ram_we,
  output logic [ADDRWIDTH-1:0] ram_rd_addr,
  input  logic [DATAWIDTH-1:0] ram_rd_data,
  input  logic                 rd_req,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 rd_last,
  output logic                 armed,
  output logic                 done,
  output logic [ADDRWIDTH-1:0] trig_addr
);

  localparam int unsigned DEPTH = 2 ** ADDRWIDTH;
  localparam int unsigned CNTW  = ADDRWIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_POST  = 3'd2,
    S_DONE  = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDRWIDTH-1:0] wr_ptr_q, rd_ptr_q, remaining_q, trig_addr_q, post_lat_q;
  logic [CNTW-1:0]      rd_cnt_q;
  logic                 filled_q, rd_valid_q, rd_last_q;

  logic we_c, issue_c, last_issue_c, trig_hit_c, start_rd_c, arm_ok_c;

  // Next-state and per-cycle strobes
  always_comb begin
    state_d      = state_q;
    we_c         = 1'b0;
    issue_c      = 1'b0;
    last_issue_c = 1'b0;
    trig_hit_c   = 1'b0;
    start_rd_c   = 1'b0;
    arm_ok_c     = arm && (state_q != S_READ);
    case (state_q)
      S_IDLE: ;
      S_ARMED: begin
        we_c = in_valid;
        if (trig && in_valid) begin
          state_d    = S_POST;
          trig_hit_c = 1'b1;
        end
      end
      S_POST: begin
        if (remaining_q == '0) state_d = S_DONE;
        else                   we_c    = in_valid;
      end
      S_DONE: begin
        if (rd_req) begin
          state_d    = S_READ;
          start_rd_c = 1'b1;
        end
      end
      S_READ: begin
        issue_c = 1'b1;
        if (rd_cnt_q == CNTW'(1)) begin
          last_issue_c = 1'b1;
          state_d      = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new arm restarts capture from any state but READ
    if (arm_ok_c) begin
      state_d    = S_ARMED;
      trig_hit_c = 1'b0;
      start_rd_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Write/read pointers, trigger bookkeeping and read-side strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      trig_addr_q <= '0;
      post_lat_q  <= '0;
      rd_cnt_q    <= '0;
      filled_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      if (arm_ok_c) begin
        wr_ptr_q   <= '0;
        filled_q   <= 1'b0;
        post_lat_q <= post_count;
      end else if (we_c) begin
        wr_ptr_q <= wr_ptr_q + ADDRWIDTH'(1);
        if (wr_ptr_q == ADDRWIDTH'(DEPTH - 1)) filled_q <= 1'b1;
      end

      if (trig_hit_c) begin
        trig_addr_q <= wr_ptr_q;
        remaining_q <= post_lat_q;
      end else if ((state_q == S_POST) && we_c) begin
        remaining_q <= remaining_q - ADDRWIDTH'(1);
      end

      // Once wrapped, the oldest sample sits at wr_ptr and the whole RAM is valid
      if (start_rd_c) begin
        rd_ptr_q <= filled_q ? wr_ptr_q : '0;
        rd_cnt_q <= filled_q ? CNTW'(DEPTH) : {1'b0, wr_ptr_q};
      end else if (issue_c) begin
        rd_ptr_q <= rd_ptr_q + ADDRWIDTH'(1);
        rd_cnt_q <= rd_cnt_q - CNTW'(1);
      end

      rd_valid_q <= issue_c;
      rd_last_q  <= last_issue_c;
    end
  end

  assign ram_we      = we_c;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = in_data;
  assign ram_rd_addr = rd_ptr_q;
  assign rd_data     = ram_rd_data;
  assign rd_valid    = rd_valid_q;
  assign rd_last     = rd_last_q;
  assign armed       = (state_q == S_ARMED) || (state_q == S_POST);
  assign done        = (state_q == S_DONE);
  assign trig_addr   = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl with a behavioural 1-cycle-latency RAM; readout words are scoreboarded.
module tb_capture_ctrl;

  localparam int unsigned DW = 18;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0, arm = 1'b0, trig = 1'b0, in_valid = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] post_count = '0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr, trig_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data, rd_data;
  logic          ram_we, rd_valid, rd_last, armed, done;

  always #5 clk = ~clk;

  capture_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig(trig), .post_count(post_count),
    .in_data(in_data), .in_valid(in_valid),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_we(ram_we),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .armed(armed), .done(done), .trig_addr(trig_addr)
  );

  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   wr_count = 0;

  // Readout scoreboard and write counter
  always @(negedge clk) begin
    if (ram_we) wr_count++;
    if (rd_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_data=%0d rd_last=%0b, required no rd_valid", rd_data, rd_last);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e.data || rd_last !== e.last) begin
          n_fail++;
          $display("FAIL rd_word: got data=%0d last=%0b, required data=%0d last=%0b",
                   rd_data, rd_last, e.data, e.last);
        end
      end
    end else if (rd_last !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rd_last_alone: got rd_last=%0b without rd_valid, required 0", rd_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [AW-1:0] pc);
    arm = 1'b1;
    post_count = pc;
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input int d, input logic t, input logic v, input logic exp_we);
    in_data  = DW'(d);
    trig     = t;
    in_valid = v;
    #1;
    n_tests++;
    if (ram_we !== exp_we) begin
      n_fail++;
      $display("FAIL ram_we(sample %0d): got %0b, required %0b", d, ram_we, exp_we);
    end
    tick();
    in_valid = 1'b0;
    trig     = 1'b0;
  endtask

  task automatic do_read();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) exp_q.push_back('{data: DW'(v), last: (v == hi)});
  endtask

  task automatic wait_done(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done === 1'b1) break;
      tick();
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_timeout: got done=%0b, required 1 within %0d cycles", name, done, bound);
    end
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_cap(input string name, input int exp_trig, input int exp_wr);
    n_tests++;
    if (trig_addr !== AW'(exp_trig) || wr_count != exp_wr) begin
      n_fail++;
      $display("FAIL %s_capture: got trig_addr=%0d writes=%0d, required trig_addr=%0d writes=%0d",
               name, trig_addr, wr_count, exp_trig, exp_wr);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_tests++;
    if ({armed, done, ram_we, rd_valid, rd_last} !== 5'b0 ||
        trig_addr !== '0 || ram_wr_addr !== '0 || ram_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL %s_outputs: got armed=%0b done=%0b we=%0b rv=%0b rl=%0b ta=%0d wa=%0d ra=%0d, required all 0",
               name, armed, done, ram_we, rd_valid, rd_last, trig_addr, ram_wr_addr, ram_rd_addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_basic();
    wr_count = 0;
    do_arm(AW'(3));
    n_tests++;
    if (armed !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_arm: got armed=%0b done=%0b, required 1 0", armed, done);
    end
    for (int v = 0; v <= 4; v++) send(v, 1'b0, 1'b1, 1'b1);
    send(5, 1'b1, 1'b1, 1'b1);
    for (int v = 6; v <= 8; v++) send(v, 1'b0, 1'b1, 1'b1);
    wait_done("basic", 5);
    check_cap("basic", 5, 9);
    push_range(0, 8);
    do_read();
    drain("basic", 30);
  endtask

  task automatic test_wrap();
    wr_count = 0;
    do_arm(AW'(2));
    for (int v = 0; v <= 19; v++) send(v, 1'b0, 1'b1, 1'b1);
    send(20, 1'b1, 1'b1, 1'b1);
    send(21, 1'b0, 1'b1, 1'b1);
    send(22, 1'b0, 1'b1, 1'b1);
    wait_done("wrap", 5);
    check_cap("wrap", 4, 23);
    push_range(7, 22);
    do_read();
    drain("wrap", 40);
  endtask

  task automatic test_post_zero();
    wr_count = 0;
    do_arm(AW'(0));
    for (int v = 0; v <= 2; v++) send(v, 1'b0, 1'b1, 1'b1);
    send(3, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (done !== 1'b0 || armed !== 1'b1) begin
      n_fail++;
      $display("FAIL post0_after_trig: got done=%0b armed=%0b, required 0 1", done, armed);
    end
    send(100, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL post0_done: got done=%0b, required 1", done);
    end
    send(101, 1'b0, 1'b1, 1'b0);
    check_cap("post0", 3, 4);
    push_range(0, 3);
    do_read();
    drain("post0", 20);
  endtask

  task automatic test_gaps();
    wr_count = 0;
    do_arm(AW'(3));
    send(0, 1'b0, 1'b1, 1'b1);
    send(1, 1'b0, 1'b1, 1'b1);
    send(2, 1'b1, 1'b1, 1'b1);
    send(3, 1'b0, 1'b1, 1'b1);
    send(50, 1'b0, 1'b0, 1'b0);
    send(51, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (armed !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_stall: got armed=%0b done=%0b, required 1 0", armed, done);
    end
    send(4, 1'b0, 1'b1, 1'b1);
    send(5, 1'b0, 1'b1, 1'b1);
    send(6, 1'b0, 1'b1, 1'b0);
    wait_done("gaps", 5);
    check_cap("gaps", 2, 6);
    push_range(0, 5);
    do_read();
    drain("gaps", 20);
  endtask

  task automatic test_reset_mid();
    wr_count = 0;
    do_arm(AW'(5));
    send(0, 1'b0, 1'b1, 1'b1);
    send(1, 1'b0, 1'b1, 1'b1);
    send(2, 1'b1, 1'b1, 1'b1);
    send(3, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("reset_post");
    send(9, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (armed !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_trig_ignored: got armed=%0b done=%0b, required 0 0", armed, done);
    end
    do_arm(AW'(0));
    for (int v = 0; v <= 5; v++) send(v, 1'b0, 1'b1, 1'b1);
    send(6, 1'b1, 1'b1, 1'b1);
    wait_done("reset_read", 5);
    push_range(0, 6);
    do_read();
    tick();
    reset = 1'b1;
    tick();
    exp_q.delete();
    reset = 1'b0;
    check_idle_outputs("reset_read");
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_ignored_ctrl();
    wr_count = 0;
    do_arm(AW'(1));
    send(0, 1'b0, 1'b1, 1'b1);
    send(1, 1'b0, 1'b1, 1'b1);
    send(2, 1'b1, 1'b1, 1'b1);
    send(3, 1'b0, 1'b1, 1'b1);
    wait_done("arm_in_read", 5);
    push_range(0, 3);
    do_read();
    arm = 1'b1;
    post_count = AW'(7);
    tick();
    arm = 1'b0;
    n_tests++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_in_read: got armed=%0b, required 0", armed);
    end
    drain("arm_in_read", 20);
    n_tests++;
    if (done !== 1'b1 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_in_read_end: got done=%0b armed=%0b, required 1 0", done, armed);
    end
    wr_count = 0;
    do_arm(AW'(2));
    do_read();
    n_tests++;
    if (armed !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdreq_in_armed: got armed=%0b rd_valid=%0b, required 1 0", armed, rd_valid);
    end
    tick();
    tick();
    send(10, 1'b0, 1'b1, 1'b1);
    send(11, 1'b0, 1'b1, 1'b1);
    send(12, 1'b1, 1'b1, 1'b1);
    send(13, 1'b0, 1'b1, 1'b1);
    send(14, 1'b0, 1'b1, 1'b1);
    wait_done("rdreq_in_armed", 5);
    check_cap("rdreq_in_armed", 2, 5);
  endtask

  task automatic test_back_to_back();
    push_range(10, 14);
    do_read();
    drain("b2b_first", 20);
    push_range(10, 14);
    do_read();
    n_tests++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got rd_valid=%0b between streams, required 0", rd_valid);
    end
    drain("b2b_second", 20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_post_zero();
    test_gaps();
    test_reset_mid();
    test_ignored_ctrl();
    test_back_to_back();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
